// File: rtl/conv_stripe_scheduler.sv
// rtl/conv_stripe_scheduler.sv - frame sequencer for a 3x3 convolution block
// Column-major triple-pixel reads with border padding, window tag pipeline and output stream.
module conv_stripe_scheduler #(
  parameter int IMG_WIDTH    = 64,
  parameter int IMG_HEIGHT   = 64,
  parameter int PIXEL_WIDTH  = 8,
  parameter int RESULT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 12,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr_l,
  output logic [ADDR_WIDTH-1:0]   rd_addr_m,
  output logic [ADDR_WIDTH-1:0]   rd_addr_r,
  input  logic [PIXEL_WIDTH-1:0]  rd_data_l,
  input  logic [PIXEL_WIDTH-1:0]  rd_data_m,
  input  logic [PIXEL_WIDTH-1:0]  rd_data_r,
  output logic                    pb_enable,
  output logic [PIXEL_WIDTH-1:0]  pb_left,
  output logic [PIXEL_WIDTH-1:0]  pb_mid,
  output logic [PIXEL_WIDTH-1:0]  pb_right,
  input  logic [RESULT_WIDTH-1:0] pb_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic [XW-1:0]           out_x,
  output logic [YW-1:0]           out_y
);
  localparam int KW = $clog2(IMG_HEIGHT + 2);
  localparam int PW = PIXEL_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;
  typedef struct packed { logic tv; logic [XW-1:0] tx; logic [YW-1:0] ty; } tag_t;
  typedef struct packed { logic last; tag_t tag; } meta_t;
  typedef struct packed { meta_t meta; logic [PW-1:0] l; logic [PW-1:0] m; logic [PW-1:0] r; } entry_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     rd_x_q, rd_x_d;
  logic [KW-1:0]     rd_k_q, rd_k_d;
  logic              rd_done_q, rd_done_d;
  logic              infl_q, infl_d;
  meta_t             infl_meta_q, infl_meta_d;
  logic [2:0]        infl_mask_q, infl_mask_d;
  entry_t            fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        flush_q, flush_d;
  tag_t              stg_q [4];
  tag_t              stg_d [4];
  logic              pending_q, pending_d;
  logic              out_valid_q, out_valid_d;
  logic [RESULT_WIDTH-1:0] out_data_q, out_data_d;
  logic [XW-1:0]     out_x_q, out_x_d;
  logic [YW-1:0]     out_y_q, out_y_d;
  logic [PW-1:0]     pb_l_q, pb_l_d, pb_m_q, pb_m_d, pb_r_q, pb_r_d;

  logic                  row_ok, last_col, last_row, stall, pb_en, pop, rd_go, capture;
  logic [2:0]            lane_mask;
  logic [1:0]            credits_after;
  logic [ADDR_WIDTH-1:0] row_base;
  entry_t                new_entry;

  // Row index k is offset by one so k=0 and k=H+1 are the zero padding rows.
  assign row_ok    = (rd_k_q != '0) && (rd_k_q <= KW'(IMG_HEIGHT));
  assign last_col  = (rd_x_q == XW'(IMG_WIDTH - 1));
  assign last_row  = (rd_k_q == KW'(IMG_HEIGHT + 1));
  assign lane_mask = {row_ok && (rd_x_q != '0), row_ok, row_ok && !last_col};
  assign row_base  = (ADDR_WIDTH'(rd_k_q) - ADDR_WIDTH'(1)) * ADDR_WIDTH'(IMG_WIDTH)
                   + ADDR_WIDTH'(rd_x_q);

  assign stall   = pending_q && out_valid_q && !out_ready;
  assign pb_en   = !reset && !stall &&
                   (((state_q == S_FEED) && (cnt_q != 2'd0)) ||
                    ((state_q == S_FLUSH) && (flush_q != 2'd3)));
  assign pop     = pb_en && (state_q == S_FEED);
  assign credits_after = 2'(infl_q) + cnt_q - 2'(pop);
  assign rd_go   = !reset && (state_q == S_FEED) && !rd_done_q && (credits_after < 2'd2);
  assign capture = pending_q && (!out_valid_q || out_ready);
  assign new_entry = {infl_meta_q,
                      rd_data_l & {PW{infl_mask_q[2]}},
                      rd_data_m & {PW{infl_mask_q[1]}},
                      rd_data_r & {PW{infl_mask_q[0]}}};

  assign busy      = !reset && ((state_q == S_FEED) || (state_q == S_FLUSH));
  assign done      = !reset && (state_q == S_DONE);
  assign rd_en     = rd_go;
  assign rd_addr_l = (rd_go && lane_mask[2]) ? row_base - ADDR_WIDTH'(1) : '0;
  assign rd_addr_m = (rd_go && lane_mask[1]) ? row_base : '0;
  assign rd_addr_r = (rd_go && lane_mask[0]) ? row_base + ADDR_WIDTH'(1) : '0;
  assign pb_enable = pb_en;
  assign pb_left   = pb_l_q;
  assign pb_mid    = pb_m_q;
  assign pb_right  = pb_r_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

  always_comb begin
    state_d = state_q;   rd_x_d = rd_x_q;   rd_k_d = rd_k_q;   rd_done_d = rd_done_q;
    infl_d = rd_go;      infl_meta_d = infl_meta_q;   infl_mask_d = infl_mask_q;
    fifo0_d = fifo0_q;   fifo1_d = fifo1_q; cnt_d = cnt_q;     flush_d = flush_q;
    stg_d = stg_q;       pending_d = pending_q;
    out_valid_d = out_valid_q; out_data_d = out_data_q; out_x_d = out_x_q; out_y_d = out_y_q;
    pb_l_d = pb_l_q;     pb_m_d = pb_m_q;   pb_r_d = pb_r_q;

    if (rd_go) begin
      infl_meta_d = {last_col && last_row, rd_k_q >= KW'(2), rd_x_q, YW'(rd_k_q - KW'(2))};
      infl_mask_d = lane_mask;
      if (last_row) begin
        rd_k_d = '0;
        if (last_col) rd_done_d = 1'b1;
        else          rd_x_d = rd_x_q + XW'(1);
      end else begin
        rd_k_d = rd_k_q + KW'(1);
      end
    end

    case ({infl_q, pop})
      2'b01: begin fifo0_d = fifo1_q; cnt_d = cnt_q - 2'd1; end
      2'b10: begin
        if (cnt_q == 2'd0) fifo0_d = new_entry;
        else               fifo1_d = new_entry;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) fifo0_d = new_entry;
        else begin fifo0_d = fifo1_q; fifo1_d = new_entry; end
      end
      default: ;
    endcase

    // Capture samples pb_result before an enable on the same edge advances the block.
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = pb_result;
      out_x_d     = stg_q[3].tx;
      out_y_d     = stg_q[3].ty;
      pending_d   = 1'b0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (pb_en) begin
      stg_d[0] = (state_q == S_FEED) ? fifo0_q.meta.tag : '0;
      stg_d[1] = stg_q[0];
      stg_d[2] = stg_q[1];
      stg_d[3] = stg_q[2];
      if (stg_q[2].tv) pending_d = 1'b1;
      pb_l_d = (state_q == S_FEED) ? fifo0_q.l : '0;
      pb_m_d = (state_q == S_FEED) ? fifo0_q.m : '0;
      pb_r_d = (state_q == S_FEED) ? fifo0_q.r : '0;
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FEED;
        rd_x_d = '0; rd_k_d = '0; rd_done_d = 1'b0; cnt_d = '0; flush_d = '0;
      end
      S_FEED:  if (pop && fifo0_q.meta.last) begin state_d = S_FLUSH; flush_d = '0; end
      S_FLUSH: begin
        if (pb_en) flush_d = flush_q + 2'd1;
        if ((flush_q == 2'd3) && !out_valid_q && !pending_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  rd_x_q <= '0;  rd_k_q <= '0;  rd_done_q <= 1'b0;
      infl_q <= 1'b0;     infl_meta_q <= '0;  infl_mask_q <= '0;
      fifo0_q <= '0;      fifo1_q <= '0; cnt_q <= '0;   flush_q <= '0;
      stg_q <= '{default: '0};  pending_q <= 1'b0;
      out_valid_q <= 1'b0; out_data_q <= '0; out_x_q <= '0; out_y_q <= '0;
      pb_l_q <= '0;       pb_m_q <= '0;  pb_r_q <= '0;
    end else begin
      state_q <= state_d; rd_x_q <= rd_x_d; rd_k_q <= rd_k_d; rd_done_q <= rd_done_d;
      infl_q <= infl_d;   infl_meta_q <= infl_meta_d; infl_mask_q <= infl_mask_d;
      fifo0_q <= fifo0_d; fifo1_q <= fifo1_d; cnt_q <= cnt_d; flush_q <= flush_d;
      stg_q <= stg_d;     pending_q <= pending_d;
      out_valid_q <= out_valid_d; out_data_q <= out_data_d; out_x_q <= out_x_d; out_y_q <= out_y_d;
      pb_l_q <= pb_l_d;   pb_m_q <= pb_m_d; pb_r_q <= pb_r_d;
    end
  end
endmodule

// File: tb/tb_conv_stripe_scheduler.sv
// tb/tb_conv_stripe_scheduler.sv - bench for conv_stripe_scheduler
// Frame buffer and 3x3 block models drive the DUT; results are compared with a padded convolution.
module tb_conv_stripe_scheduler;
  localparam int W = 4, H = 3, AW = 12, XW = 2, YW = 2;

  logic clk = 1'b0;
  logic reset, start, busy, done, rd_en, pb_enable, out_valid, out_ready;
  logic [AW-1:0] rd_addr_l, rd_addr_m, rd_addr_r;
  logic [7:0] rd_data_l, rd_data_m, rd_data_r, pb_left, pb_mid, pb_right, pb_result, out_data;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  always #5 clk = ~clk;

  conv_stripe_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8),
                          .RESULT_WIDTH(8), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_l(rd_addr_l), .rd_addr_m(rd_addr_m), .rd_addr_r(rd_addr_r),
    .rd_data_l(rd_data_l), .rd_data_m(rd_data_m), .rd_data_r(rd_data_r),
    .pb_enable(pb_enable), .pb_left(pb_left), .pb_mid(pb_mid), .pb_right(pb_right),
    .pb_result(pb_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y));

  logic [7:0] mem [W*H];
  int coef = 14;

  function automatic logic [7:0] fb(input logic [AW-1:0] a);
    if (int'(a) < W*H) return mem[a];
    return 8'hEE;
  endfunction

  always @(posedge clk) if (rd_en) begin
    rd_data_l <= fb(rd_addr_l);
    rd_data_m <= fb(rd_addr_m);
    rd_data_r <= fb(rd_addr_r);
  end

  // 3x3 block: bottom row is the live pb_* inputs, rows shift up and a 3-deep MAC pipe advances per enable.
  logic [7:0] top [3];
  logic [7:0] mid [3];
  logic [7:0] p1, p2, p3;
  function automatic logic [7:0] win_val();
    int s;
    s = int'(pb_left) + int'(pb_mid) + int'(pb_right);
    for (int i = 0; i < 3; i++) s += int'(top[i]) + int'(mid[i]);
    return 8'((s * coef) >> 8);
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      top <= '{default: 8'd0}; mid <= '{default: 8'd0};
      p1 <= 8'd0; p2 <= 8'd0; p3 <= 8'd0;
    end else if (pb_enable) begin
      p1 <= win_val(); p2 <= p1; p3 <= p2;
      top <= mid;
      mid <= '{pb_left, pb_mid, pb_right};
    end
  end
  assign pb_result = p3;

  logic [31:0] res_x [$], res_y [$], res_d [$];
  int cyc, rd_tot, pb_tot, done_tot, fr_rd, fr_pb, cred_viol, stab_viol, last_hs_cyc, done_cyc;
  bit hold;
  logic [7:0] sd;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      fr_rd = 0; fr_pb = 0; hold = 0;
    end else begin
      if (hold && (!out_valid || out_data !== sd || out_x !== sx || out_y !== sy)) stab_viol++;
      hold = out_valid && !out_ready;
      sd = out_data; sx = out_x; sy = out_y;
      if (out_valid && out_ready) begin
        res_x.push_back(32'(out_x)); res_y.push_back(32'(out_y)); res_d.push_back(32'(out_data));
        last_hs_cyc = cyc;
      end
      if (rd_en) begin
        if (fr_rd - fr_pb - (pb_enable ? 1 : 0) >= 2) cred_viol++;
        fr_rd++; rd_tot++;
      end
      if (pb_enable) begin fr_pb++; pb_tot++; end
      if (done) begin done_tot++; done_cyc = cyc; fr_rd = 0; fr_pb = 0; end
    end
  end

  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int ref_px(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 0;
    return int'(mem[y*W + x]);
  endfunction

  function automatic int ref_out(input int x, input int y);
    int s = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++) s += ref_px(x + dx, y + dy);
    return ((s * coef) >> 8) & 255;
  endfunction

  function automatic logic [31:0] res_at(input int which, input int i);
    if (i >= res_d.size()) return 'x;
    case (which)
      0: return res_x[i];
      1: return res_y[i];
      default: return res_d[i];
    endcase
  endfunction

  task automatic compare_frame(input string name, input int base);
    int idx = base;
    check({name, " count"}, 32'(res_d.size() - base), W*H);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        check($sformatf("%s x#%0d", name, idx - base), res_at(0, idx), x);
        check($sformatf("%s y#%0d", name, idx - base), res_at(1, idx), y);
        check($sformatf("%s data(%0d,%0d)", name, x, y), res_at(2, idx), ref_out(x, y));
        idx++;
      end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < W*H; i++) mem[i] = 8'(v);
  endtask

  // mode 0: ready high, 1: hold ready low 10 cycles at first result, 2: random ready, 3: start pulses while busy
  task automatic run_frame(input int mode);
    int held = 0;
    bit finished = 0;
    out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    check("busy after start", busy, 1);
    for (int c = 0; c < 3000 && !finished; c++) begin
      if (mode == 1 && out_valid && held < 10) begin
        out_ready = 1'b0;
        held++;
        if (held == 10) begin
          #1;
          check("hold pb_enable", pb_enable, 0);
          check("hold out_valid", out_valid, 1);
        end
      end else if (mode == 2) out_ready = ($urandom_range(0, 99) < 60);
      else out_ready = 1'b1;
      if (mode == 3) start = (c % 5 == 2);
      step();
      finished = done;
    end
    check("frame done", finished, 1);
    out_ready = 1'b1;
    start = (mode == 3);
    step();
    if (mode == 3) check("start in done ignored", busy, 0);
  endtask

  initial begin
    int base, rd0, pb0, d0;
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    fill(0);
    repeat (3) step();
    check("rst busy", busy, 0);           check("rst done", done, 0);
    check("rst rd_en", rd_en, 0);         check("rst pb_enable", pb_enable, 0);
    check("rst out_valid", out_valid, 0); check("rst out_data", out_data, 0);
    check("rst out_x", out_x, 0);         check("rst out_y", out_y, 0);
    check("rst pb_left", pb_left, 0);     check("rst pb_mid", pb_mid, 0);
    check("rst pb_right", pb_right, 0);   check("rst rd_addr_m", rd_addr_m, 0);
    reset = 1'b0;
    step();

    fill(100); coef = 14;
    base = res_d.size(); rd0 = rd_tot; pb0 = pb_tot; d0 = done_tot;
    run_frame(0);
    compare_frame("flat", base);
    check("flat corner", res_at(2, base + 0), 21);
    check("flat edge", res_at(2, base + 1), 32);
    check("flat interior(1,1)", res_at(2, base + 4), 49);
    check("flat interior(2,1)", res_at(2, base + 7), 49);
    check("rd_en pulses", 32'(rd_tot - rd0), 20);
    check("pb_enable pulses", 32'(pb_tot - pb0), 23);
    check("done pulses", 32'(done_tot - d0), 1);
    check("done after last handshake", 32'(done_cyc > last_hs_cyc), 1);
    check("credit violations", 32'(cred_viol), 0);

    base = res_d.size();
    run_frame(1);
    compare_frame("hold", base);
    check("hold stability", 32'(stab_viol), 0);

    fill(0); mem[1*W + 3] = 8'd255;
    base = res_d.size();
    run_frame(0);
    compare_frame("impulse", base);
    check("impulse (3,1)", res_at(2, base + 3*H + 1), 13);
    check("impulse (2,0)", res_at(2, base + 2*H), 13);
    check("impulse no wrap (0,1)", res_at(2, base + 1), 0);

    fill(100);
    start = 1'b1; step(); start = 1'b0;
    repeat (7) step();
    reset = 1'b1; step();
    check("midrst busy", busy, 0);           check("midrst out_valid", out_valid, 0);
    check("midrst rd_en", rd_en, 0);         check("midrst pb_enable", pb_enable, 0);
    reset = 1'b0; step();
    base = res_d.size();
    run_frame(0);
    compare_frame("after reset", base);

    base = res_d.size(); d0 = done_tot;
    run_frame(3);
    compare_frame("start while busy", base);
    check("single done", 32'(done_tot - d0), 1);
    base = res_d.size();
    run_frame(0);
    compare_frame("back to back", base);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom_range(0, 255));
      coef = $urandom_range(1, 28);
      base = res_d.size();
      run_frame(2);
      compare_frame($sformatf("random%0d", f), base);
    end
    check("final stability", 32'(stab_viol), 0);
    check("final credit violations", 32'(cred_viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_stripe_scheduler.md
Name: conv_stripe_scheduler

Overview:
Frame-level sequencer for one 3x3 convolution processing block, which has three column inputs, an upward row shift on enable and a 3-enable MAC pipeline.
- Walks a W x H pixel image in column-major order and issues triple-pixel reads (col-1, col, col+1) from a 1-cycle-latency frame buffer.
- Applies zero padding at all four image borders.
- Drives the block's enable and tracks window validity through its pipeline.
- Emits one (x, y, result) per output pixel on a valid/ready stream with backpressure.

Parameters:
IMG_WIDTH, 64, image width W in pixels (>=2)
IMG_HEIGHT, 64, image height H in pixels (>=2)
PIXEL_WIDTH, 8, pixel bit width
RESULT_WIDTH, 8, processing-block result width
ADDR_WIDTH, 12, frame buffer address width (>= clog2(W*H))

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  begin frame; ignored while busy
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse, frame complete
rd_en  out  1  frame buffer read strobe
rd_addr_l/rd_addr_m/rd_addr_r  out  ADDR_WIDTH  addresses, row*W+col
rd_data_l/rd_data_m/rd_data_r  in  PIXEL_WIDTH  read data, valid exactly 1 cycle after rd_en
pb_enable  out  1  processing-block advance
pb_left/pb_mid/pb_right  out  PIXEL_WIDTH  processing-block row inputs (masked)
pb_result  in  RESULT_WIDTH  processing-block filter output
out_valid  out  1  result valid
out_ready  in  1  consumer accept
out_data  out  RESULT_WIDTH  result
out_x  out  clog2(W)  result column
out_y  out  clog2(H)  result row

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE; buffer, tags, pending flag and counters cleared. Same reset drives the processing block.
- FSM: IDLE -start-> FEED -last feed issued-> FLUSH -3 flush enables done and out_valid=0 and no pending-> DONE (done=1 for one cycle) -> IDLE.
- Feed order: for x = 0..W-1, k = 0..H+1 (row r = k-1), W*(H+2) feeds, columns back-to-back with no gap.
- Each feed pulses rd_en. Out-of-range coordinates (row -1/H, col -1/W) use address 0, and a 3-bit mask zeroes that lane. Padding rows zero all three lanes.
- 2-entry input FIFO holds {data AND mask}. Track read credits as in-flight reads plus FIFO occupancy, at most 2. Issue rd_en only when credits after this cycle's pop are <2. Throughput is 1 feed/cycle when unstalled.
- stall = pending && out_valid && !out_ready.
- pb_enable = !stall && (FIFO non-empty in FEED, or flush count <3 in FLUSH). On a pb_enable cycle:
  - pop the FIFO onto pb_left/mid/right;
  - in FLUSH, drive zeros instead.
  Otherwise pb_* hold their last value.
- Tags: the feed with k>=2 carries tag {valid=1, x, y=k-2}; k<2 and flush entries carry valid=0.
  - The tag enters stage0 on the enable that loads that row.
  - It shifts through stage1, stage2, stage3 only on pb_enable.
  - When an enable moves a valid tag into stage3, set pending.
  - No window spanning two columns is ever emitted.
- Capture: when pending && (!out_valid || out_ready), load out_data=pb_result and out_x/out_y from stage3, set out_valid, clear pending. This may coincide with a pb_enable, which samples pb_result before its edge update.
- out_valid drops on out_valid && out_ready unless a capture occurs in the same cycle. out_* hold stable while out_valid && !out_ready.
- Emission is strictly column-major: W*H results per frame.
- start during busy or DONE: ignored. start in the cycle after done: accepted.
- Reset mid-frame: next cycle busy=0, out_valid=0, rd_en=0, pb_enable=0. A partial frame is never resumed.

Test Plan:
- W=4,H=3, all pixels 100, filter 14/256 each: 12 results in order (0,0),(0,1),(0,2),(1,0)...; corner=21, edge=32, interior (1,1),(2,1)=49; done once after last handshake.
- Same run, count strobes: rd_en pulses=20, pb_enable pulses=23, rd_en never issued with credits=2.
- Hold out_ready=0 for 10 cycles at first out_valid: out_data/x/y stable, pb_enable=0 while pending, no result lost; results afterwards identical to the first scenario.
- Impulse 255 at (3,1), others 0: results 13 at x=2..3,y=0..2; all other results 0; column 0 of the next pass unaffected (no wrap).
- Assert reset 7 cycles into FEED: next cycle busy/out_valid/rd_en/pb_enable all 0. Then start: full correct frame as in the first scenario.
- start pulses while busy are ignored (single frame, 12 results); start the cycle after done begins a second identical frame.
